// File: rtl/bist_seed_sequencer.sv
// Multi-session BIST sequencer: runs one wrapper session per seed, checks each
// signature against its golden value and accumulates a fail mask and pass flag.
module bist_seed_sequencer #(
  parameter int unsigned                NUM_SEEDS      = 4,
  parameter logic [4*NUM_SEEDS-1:0]     SEED_LIST      = 16'h9531,
  parameter logic [8*NUM_SEEDS-1:0]     EXP_SIG_LIST   = 32'h27272727,
  parameter int unsigned                TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 bist_end,
  input  logic [7:0]           signature,
  output logic [3:0]           lfsr_seed,
  output logic                 dut_reset,
  output logic                 bist_start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_SEEDS-1:0] fail_mask,
  output logic                 timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST1,
    S_RST2,
    S_GO,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [2:0]  LAST_IDX = 3'(NUM_SEEDS - 1);
  localparam logic [15:0] TMO      = 16'(TIMEOUT_CYCLES);

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   bend_prev_q, bend_prev_d;
  logic [3:0]             seed_q, seed_d;
  logic                   dut_reset_q, dut_reset_d;
  logic                   bist_start_q, bist_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [NUM_SEEDS-1:0]   fail_mask_q, fail_mask_d;
  logic                   timeout_q, timeout_d;

  logic [15:0]            cnt_inc;
  logic [NUM_SEEDS-1:0]   mask_bit;
  logic                   edge_seen;

  function automatic logic [3:0] seed_of(input logic [2:0] i);
    seed_of = SEED_LIST[3:0];
    for (int k = 0; k < int'(NUM_SEEDS); k++)
      if (i == 3'(k)) seed_of = SEED_LIST[4*k +: 4];
  endfunction

  function automatic logic [7:0] sig_of(input logic [2:0] i);
    sig_of = EXP_SIG_LIST[7:0];
    for (int k = 0; k < int'(NUM_SEEDS); k++)
      if (i == 3'(k)) sig_of = EXP_SIG_LIST[8*k +: 8];
  endfunction

  assign mask_bit  = NUM_SEEDS'(1) << idx_q;
  assign edge_seen = bist_end & ~bend_prev_q;
  assign cnt_inc   = (cnt_q == TMO) ? cnt_q : cnt_q + 16'd1;

  // Outputs are computed one state ahead so every port comes straight off a flop.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    bend_prev_d  = bist_end;
    seed_d       = seed_q;
    dut_reset_d  = dut_reset_q;
    bist_start_d = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_mask_d  = fail_mask_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          fail_mask_d = '0;
          timeout_d   = 1'b0;
          pass_d      = 1'b0;
          idx_d       = 3'd0;
          seed_d      = seed_of(3'd0);
          dut_reset_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          state_d     = S_RST1;
        end
      end
      S_RST1: state_d = S_RST2;
      S_RST2: begin
        dut_reset_d  = 1'b0;
        bist_start_d = 1'b1;
        cnt_d        = 16'd0;
        state_d      = S_GO;
      end
      S_GO: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_inc;
        // A genuine completion beats the timeout when both land on the same edge.
        if (edge_seen) begin
          state_d = S_CHECK;
        end else if (cnt_inc == TMO) begin
          fail_mask_d = fail_mask_q | mask_bit;
          timeout_d   = 1'b1;
          state_d     = S_NEXT;
        end
      end
      S_CHECK: begin
        if (signature != sig_of(idx_q)) fail_mask_d = fail_mask_q | mask_bit;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_mask_q == '0);
          state_d = S_DONE;
        end else begin
          idx_d       = idx_q + 3'd1;
          seed_d      = seed_of(idx_q + 3'd1);
          dut_reset_d = 1'b1;
          state_d     = S_RST1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= 16'd0;
      bend_prev_q  <= 1'b0;
      seed_q       <= SEED_LIST[3:0];
      dut_reset_q  <= 1'b0;
      bist_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_mask_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      bend_prev_q  <= bend_prev_d;
      seed_q       <= seed_d;
      dut_reset_q  <= dut_reset_d;
      bist_start_q <= bist_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_mask_q  <= fail_mask_d;
      timeout_q    <= timeout_d;
    end
  end

  assign lfsr_seed  = seed_q;
  assign dut_reset  = dut_reset_q;
  assign bist_start = bist_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_mask  = fail_mask_q;
  assign timeout    = timeout_q;

endmodule
